// File: rtl/stack_pkg.sv
// Shared command encoding and default geometry for the stack CPU datapath
// (the operand stack, the 32x8 memory and the ALU).
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 8;

    // Encoded as {push, pop}.
    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_POP     = 2'b01,
        CMD_PUSH    = 2'b10,
        CMD_REPLACE = 2'b11
    } stack_cmd_t;

endpackage

// File: rtl/operand_stack.sv
// Operand stack feeding TOS/NOS to the ALU and TOS to memory on pops.
// One command per cycle, sticky overflow/underflow flags, stale entries masked.
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [DW-1:0]    depth_q;
    logic             overflow_q;
    logic             underflow_q;
    stack_cmd_t       cmd;

    logic             is_empty;
    logic             is_full;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    next_idx;
    logic [IW-1:0]    second_idx;

    assign cmd      = stack_cmd_t'({push, pop});
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(DEPTH));

    // Indices are truncated to IW bits; each use is guarded so truncation never aliases.
    assign next_idx   = IW'(depth_q);
    assign top_idx    = IW'(depth_q - DW'(1));
    assign second_idx = IW'(depth_q - DW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (cmd)
                CMD_PUSH: begin
                    if (is_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        mem[next_idx] <= data_in;
                        depth_q       <= depth_q + DW'(1);
                    end
                end
                CMD_POP: begin
                    if (is_empty) begin
                        underflow_q <= 1'b1;
                    end else begin
                        depth_q <= depth_q - DW'(1);
                    end
                end
                CMD_REPLACE: begin
                    // Replace on an empty stack still lands the value, but is flagged.
                    if (is_empty) begin
                        mem[0]      <= data_in;
                        depth_q     <= DW'(1);
                        underflow_q <= 1'b1;
                    end else begin
                        mem[top_idx] <= data_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        tos = '0;
        nos = '0;
        if (depth_q >= DW'(1)) tos = mem[top_idx];
        if (depth_q >= DW'(2)) nos = mem[second_idx];
    end

    assign depth     = depth_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: ALU-style sequences, full/empty boundaries,
// reset priority and output masking of stale entries.
module tb_operand_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] tos;
    logic [7:0] nos;
    logic [3:0] depth;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    operand_stack #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Apply one command on the falling edge, let a rising edge sample it, look 1 ns later.
    task automatic step(input logic r, input logic p, input logic po, input logic [7:0] d);
        @(negedge clk);
        rst = r; push = p; pop = po; data_in = d;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (depth !== 4'd0) begin fails++; $display("FAIL reset_depth got %0d want 0", depth); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (tos !== 8'h00) begin fails++; $display("FAIL reset_tos got %h want 00", tos); end
        tests++; if (nos !== 8'h00) begin fails++; $display("FAIL reset_nos got %h want 00", nos); end
        tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_push_add();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h08);
        step(1'b0, 1'b1, 1'b0, 8'h08);
        tests++; if (tos !== 8'h08) begin fails++; $display("FAIL add_tos got %h want 08", tos); end
        tests++; if (nos !== 8'h08) begin fails++; $display("FAIL add_nos got %h want 08", nos); end
        tests++; if (depth !== 4'd2) begin fails++; $display("FAIL add_depth got %0d want 2", depth); end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h10);
        tests++; if (tos !== 8'h10) begin fails++; $display("FAIL add_result_tos got %h want 10", tos); end
        tests++; if (depth !== 4'd1) begin fails++; $display("FAIL add_result_depth got %0d want 1", depth); end
        tests++; if (nos !== 8'h00) begin fails++; $display("FAIL add_result_nos got %h want 00", nos); end
    endtask

    task automatic test_bitwise();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 1'b0, 8'h66);
        tests++; if ({tos, nos} !== 16'h66AA) begin fails++; $display("FAIL bit_pushes got %h want 66aa", {tos, nos}); end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (tos !== 8'hAA) begin fails++; $display("FAIL bit_pop_tos got %h want aa", tos); end
        step(1'b0, 1'b1, 1'b1, 8'h22);
        tests++; if (tos !== 8'h22) begin fails++; $display("FAIL bit_and_tos got %h want 22", tos); end
        step(1'b0, 1'b1, 1'b1, 8'hDD);
        tests++; if (tos !== 8'hDD) begin fails++; $display("FAIL bit_not_tos got %h want dd", tos); end
        tests++; if (depth !== 4'd1) begin fails++; $display("FAIL bit_not_depth got %0d want 1", depth); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", full); end
        tests++; if (tos !== 8'h08) begin fails++; $display("FAIL full_tos got %h want 08", tos); end
        tests++; if (nos !== 8'h07) begin fails++; $display("FAIL full_nos got %h want 07", nos); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_no_ovf got %b want 0", overflow); end
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        tests++; if (tos !== 8'h08) begin fails++; $display("FAIL ovf_tos got %h want 08", tos); end
        tests++; if (depth !== 4'd8) begin fails++; $display("FAIL ovf_depth got %0d want 8", depth); end
        step(1'b0, 1'b1, 1'b1, 8'h55);
        tests++; if (tos !== 8'h55) begin fails++; $display("FAIL full_repl_tos got %h want 55", tos); end
        tests++; if (nos !== 8'h07) begin fails++; $display("FAIL full_repl_nos got %h want 07", nos); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        tests++; if (depth !== 4'd8) begin fails++; $display("FAIL full_repl_depth got %0d want 8", depth); end
    endtask

    task automatic test_empty();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_flag got %b want 1", underflow); end
        tests++; if (depth !== 4'd0) begin fails++; $display("FAIL unf_depth got %0d want 0", depth); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL unf_no_ovf got %b want 0", overflow); end
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        tests++; if (depth !== 4'd1) begin fails++; $display("FAIL empty_repl_depth got %0d want 1", depth); end
        tests++; if (tos !== 8'h3C) begin fails++; $display("FAIL empty_repl_tos got %h want 3c", tos); end
        tests++; if (nos !== 8'h00) begin fails++; $display("FAIL empty_repl_nos got %h want 00", nos); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_sticky got %b want 1", underflow); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'hA1);
        step(1'b0, 1'b1, 1'b0, 8'hA2);
        step(1'b0, 1'b1, 1'b0, 8'hA3);
        tests++; if (depth !== 4'd3) begin fails++; $display("FAIL prio_pre_depth got %0d want 3", depth); end
        step(1'b1, 1'b1, 1'b0, 8'h77);
        tests++; if (depth !== 4'd0) begin fails++; $display("FAIL prio_depth got %0d want 0", depth); end
        tests++; if (tos !== 8'h00) begin fails++; $display("FAIL prio_tos got %h want 00", tos); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL prio_ovf got %b want 0", overflow); end
        step(1'b0, 1'b1, 1'b0, 8'h11);
        tests++; if (tos !== 8'h11) begin fails++; $display("FAIL stale_tos got %h want 11", tos); end
        tests++; if (nos !== 8'h00) begin fails++; $display("FAIL stale_nos got %h want 00", nos); end
        tests++; if (depth !== 4'd1) begin fails++; $display("FAIL stale_depth got %0d want 1", depth); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b0, 8'h03);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if ({tos, nos} !== 16'h0201) begin fails++; $display("FAIL b2b_pop1 got %h want 0201", {tos, nos}); end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if ({tos, nos} !== 16'h0100) begin fails++; $display("FAIL b2b_pop2 got %h want 0100", {tos, nos}); end
        step(1'b0, 1'b1, 1'b0, 8'h09);
        tests++; if ({tos, nos} !== 16'h0901) begin fails++; $display("FAIL b2b_push got %h want 0901", {tos, nos}); end
        // Inputs alone, with no sampling edge, must not move any output.
        @(negedge clk);
        push = 1'b1; pop = 1'b1; data_in = 8'hEE;
        #2;
        tests++; if ({tos, depth} !== {8'h09, 4'd2}) begin fails++; $display("FAIL no_comb_path got %h/%0d want 09/2", tos, depth); end
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        test_reset();
        test_push_add();
        test_bitwise();
        test_full();
        test_empty();
        test_reset_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
